// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave exposing four 32-bit registers at 0x00, 0x04, 0x08 and 0x0C.
// The write and read channels each have their own small FSM and run concurrently.
// Optional build macro: AXIL_WSTRB_EN enables byte-lane write strobes.
// Without it, W_STRB is ignored and every valid write replaces the full word.
module axi_lite_regfile #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    A_CLK,
    input  logic                    A_RESET_n,
    input  logic [ADDR_WIDTH-1:0]   AW_ADDR,
    input  logic                    AW_VALID,
    output logic                    AW_READY,
    input  logic [DATA_WIDTH-1:0]   W_DATA,
    input  logic [DATA_WIDTH/8-1:0] W_STRB,
    input  logic                    W_VALID,
    output logic                    W_READY,
    output logic [1:0]              B_RESP,
    output logic                    B_VALID,
    input  logic                    B_READY,
    input  logic [ADDR_WIDTH-1:0]   AR_ADDR,
    input  logic                    AR_VALID,
    output logic                    AR_READY,
    output logic [DATA_WIDTH-1:0]   R_DATA,
    output logic [1:0]              R_RESP,
    output logic                    R_VALID,
    input  logic                    R_READY
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned NUM_REGS   = 4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WIDLE, WCOLLECT, WRESP} wstate_t;
    typedef enum logic       {RIDLE, RDATA} rstate_t;

    // Only word-aligned offsets inside the 16-byte window decode to a register.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a[ADDR_WIDTH-1:4] == '0) && (a[1:0] == 2'b00);
    endfunction

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // ---------------- write path ----------------
    wstate_t               wstate, wstate_d;
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  aw_hs_c, w_hs_c, commit_c;
    logic [ADDR_WIDTH-1:0] wr_addr_c;
    logic [DATA_WIDTH-1:0] wr_data_c;
    logic [DATA_WIDTH-1:0] wr_merged_c;
    logic                  wr_ok_c;
    logic                  aw_ready_d, w_ready_d, b_valid_d, aw_held_d, w_held_d;
    logic [1:0]            b_resp_d;

    assign aw_hs_c   = AW_VALID && AW_READY;
    assign w_hs_c    = W_VALID && W_READY;
    // A beat handshaking this cycle is used directly so the commit lands on the later handshake.
    assign wr_addr_c = aw_hs_c ? AW_ADDR : addr_q;
    assign wr_data_c = w_hs_c ? W_DATA : data_q;
    assign wr_ok_c   = addr_ok(wr_addr_c);
    assign commit_c  = (wstate != WRESP) && (wstate_d == WRESP);

`ifdef AXIL_WSTRB_EN
    logic [STRB_WIDTH-1:0] strb_q;
    logic [STRB_WIDTH-1:0] wr_strb_c;

    assign wr_strb_c = w_hs_c ? W_STRB : strb_q;

    // Merge enabled byte lanes of the new data into the current register value.
    always_comb begin
        wr_merged_c = regs[wr_addr_c[3:2]];
        for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
            if (wr_strb_c[b]) begin
                wr_merged_c[b*8 +: 8] = wr_data_c[b*8 +: 8];
            end
        end
    end

    // Strobes travel with the data beat.
    always_ff @(posedge A_CLK or negedge A_RESET_n) begin
        if (!A_RESET_n) begin
            strb_q <= '0;
        end else if (w_hs_c) begin
            strb_q <= W_STRB;
        end
    end
`else
    logic unused_strb_c;

    assign unused_strb_c = ^W_STRB;

    // Full-word write: strobes play no part.
    always_comb begin
        wr_merged_c = wr_data_c;
    end
`endif

    // Write FSM state register.
    always_ff @(posedge A_CLK or negedge A_RESET_n) begin
        if (!A_RESET_n) begin
            wstate <= WIDLE;
        end else begin
            wstate <= wstate_d;
        end
    end

    // Write FSM next state: collect address and data in either order, then respond.
    always_comb begin
        wstate_d = wstate;
        unique case (wstate)
            WIDLE: begin
                if (aw_hs_c && w_hs_c) begin
                    wstate_d = WRESP;
                end else if (aw_hs_c || w_hs_c) begin
                    wstate_d = WCOLLECT;
                end
            end
            WCOLLECT: begin
                if ((aw_held || aw_hs_c) && (w_held || w_hs_c)) begin
                    wstate_d = WRESP;
                end
            end
            WRESP: begin
                if (B_VALID && B_READY) begin
                    wstate_d = WIDLE;
                end
            end
            default: wstate_d = WIDLE;
        endcase
    end

    // Write outputs: one-cycle ready pulses, held flags, response on commit.
    always_comb begin
        aw_ready_d = 1'b0;
        w_ready_d  = 1'b0;
        b_valid_d  = B_VALID;
        b_resp_d   = B_RESP;
        aw_held_d  = aw_held || aw_hs_c;
        w_held_d   = w_held || w_hs_c;
        if (commit_c) begin
            b_valid_d = 1'b1;
            b_resp_d  = wr_ok_c ? RESP_OKAY : RESP_SLVERR;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else if (B_VALID && B_READY) begin
            b_valid_d = 1'b0;
        end
        // No new beat is taken while a response is pending or about to be.
        if (!commit_c && !B_VALID) begin
            aw_ready_d = AW_VALID && !AW_READY && !aw_held_d;
            w_ready_d  = W_VALID && !W_READY && !w_held_d;
        end
    end

    // Write channel output and capture registers.
    always_ff @(posedge A_CLK or negedge A_RESET_n) begin
        if (!A_RESET_n) begin
            AW_READY <= 1'b0;
            W_READY  <= 1'b0;
            B_VALID  <= 1'b0;
            B_RESP   <= RESP_OKAY;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            AW_READY <= aw_ready_d;
            W_READY  <= w_ready_d;
            B_VALID  <= b_valid_d;
            B_RESP   <= b_resp_d;
            aw_held  <= aw_held_d;
            w_held   <= w_held_d;
            if (aw_hs_c) begin
                addr_q <= AW_ADDR;
            end
            if (w_hs_c) begin
                data_q <= W_DATA;
            end
        end
    end

    // Register file: updated only on a commit to a decodable address.
    always_ff @(posedge A_CLK or negedge A_RESET_n) begin
        if (!A_RESET_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_c && wr_ok_c) begin
            regs[wr_addr_c[3:2]] <= wr_merged_c;
        end
    end

    // ---------------- read path ----------------
    rstate_t               rstate, rstate_d;
    logic                  ar_hs_c;
    logic                  ar_ready_d, r_valid_d;
    logic [DATA_WIDTH-1:0] r_data_d;
    logic [1:0]            r_resp_d;

    assign ar_hs_c = AR_VALID && AR_READY;

    // Read FSM state register.
    always_ff @(posedge A_CLK or negedge A_RESET_n) begin
        if (!A_RESET_n) begin
            rstate <= RIDLE;
        end else begin
            rstate <= rstate_d;
        end
    end

    // Read FSM next state.
    always_comb begin
        rstate_d = rstate;
        unique case (rstate)
            RIDLE:   if (ar_hs_c) rstate_d = RDATA;
            RDATA:   if (R_READY) rstate_d = RIDLE;
            default: rstate_d = RIDLE;
        endcase
    end

    // Read outputs: data is sampled from the registers at the AR handshake edge,
    // so a same-edge write commit is not visible to this read.
    always_comb begin
        ar_ready_d = (rstate == RIDLE) && (rstate_d == RIDLE) && AR_VALID && !AR_READY;
        r_valid_d  = (rstate_d == RDATA);
        r_data_d   = R_DATA;
        r_resp_d   = R_RESP;
        if (ar_hs_c) begin
            if (addr_ok(AR_ADDR)) begin
                r_data_d = regs[AR_ADDR[3:2]];
                r_resp_d = RESP_OKAY;
            end else begin
                r_data_d = '0;
                r_resp_d = RESP_SLVERR;
            end
        end
    end

    // Read channel output registers.
    always_ff @(posedge A_CLK or negedge A_RESET_n) begin
        if (!A_RESET_n) begin
            AR_READY <= 1'b0;
            R_VALID  <= 1'b0;
            R_DATA   <= '0;
            R_RESP   <= RESP_OKAY;
        end else begin
            AR_READY <= ar_ready_d;
            R_VALID  <= r_valid_d;
            R_DATA   <= r_data_d;
            R_RESP   <= r_resp_d;
        end
    end

endmodule

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 The block SHALL have one clock, A_CLK, and an asynchronous active-low reset, A_RESET_n.
REQ-002 The block SHALL have these parameters (name, default, meaning): ADDR_WIDTH, 32, address bus width; DATA_WIDTH, 32, data bus width, which is 32 in this release.
REQ-003 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- A_CLK  in  1  clock.
- A_RESET_n  in  1  asynchronous reset, active low.
- AW_ADDR  in  ADDR_WIDTH  write address.
- AW_VALID  in  1  write address valid.
- AW_READY  out  1  write address ready.
- W_DATA  in  DATA_WIDTH  write data.
- W_STRB  in  DATA_WIDTH/8  write byte strobes.
- W_VALID  in  1  write data valid.
- W_READY  out  1  write data ready.
- B_RESP  out  2  write response.
- B_VALID  out  1  write response valid.
- B_READY  in  1  write response ready.
- AR_ADDR  in  ADDR_WIDTH  read address.
- AR_VALID  in  1  read address valid.
- AR_READY  out  1  read address ready.
- R_DATA  out  DATA_WIDTH  read data.
- R_RESP  out  2  read response.
- R_VALID  out  1  read data valid.
- R_READY  in  1  read data ready.

Function
REQ-004 The block SHALL implement four 32-bit registers REG0..REG3 at addresses 0x00, 0x04, 0x08 and 0x0C.
REQ-005 An address SHALL be valid only when ADDR[ADDR_WIDTH-1:4]==0 and ADDR[1:0]==0; the response SHALL be OKAY (2'b00) for a valid address and SLVERR (2'b10) otherwise.
REQ-006 AW_READY SHALL be a registered one-cycle pulse, asserted only in the cycle after AW_VALID is sampled high while no address is held and B_VALID is low; AW_READY SHALL never be high while AW_VALID is low.
REQ-007 W_READY SHALL follow the same rule as AW_READY, using W_VALID and a separate data-held flag; address and data SHALL be accepted independently and in either order.
REQ-008 The write FSM SHALL have three states:
- WIDLE -> WCOLLECT on the first AW or W handshake.
- WCOLLECT -> WRESP when both address and data are held.
- WIDLE -> WRESP directly when both handshakes occur in the same cycle.
- WRESP -> WIDLE on B_VALID && B_READY.
REQ-009 On entry to WRESP, the block SHALL commit the write if the address is valid, assert B_VALID in that cycle with B_RESP per REQ-005, and clear the held flags; B_VALID SHALL rise exactly 1 cycle after the later handshake.
REQ-010 B_VALID and B_RESP SHALL stay stable until B_READY is sampled high; no new AW or W SHALL be accepted while B_VALID is high.
REQ-011 An invalid write address SHALL leave all registers unchanged.
REQ-012 The read FSM SHALL have two states: RIDLE and RDATA.
REQ-013 In RIDLE, AR_READY SHALL pulse for one cycle, in the cycle after AR_VALID is sampled high; the handshake SHALL capture the decoded data.
REQ-014 The read FSM SHALL move to RDATA with R_VALID high 1 cycle after the AR handshake.
REQ-015 R_DATA SHALL be the register value, or 0 on SLVERR; R_DATA and R_RESP SHALL stay stable until R_READY is sampled high, then return to RIDLE.
REQ-016 The read and write paths SHALL run concurrently.
REQ-017 When a write commit and an AR handshake to the same register fall in the same cycle, the read SHALL return the pre-write value.
REQ-018 B_VALID SHALL rise at most 2 cycles after the later of AW_VALID/W_VALID is asserted with B_VALID low, and R_VALID SHALL rise at most 1 cycle after the AR handshake.

Reset
REQ-019 Asserting A_RESET_n low SHALL immediately clear REG0..REG3, AW_READY, W_READY, B_VALID, AR_READY and R_VALID, and SHALL clear B_RESP, R_RESP and R_DATA to 0.
REQ-020 Reset SHALL return both FSMs to their idle states and drop any partially collected transaction.
REQ-021 The first AW_READY, W_READY or AR_READY after reset SHALL occur no earlier than the cycle after the first rising edge at which reset is deasserted.

Configuration
REQ-022 With AXIL_WSTRB_EN defined, a write SHALL update byte lane i only when W_STRB[i]==1, and W_STRB==4'b0000 SHALL return OKAY with the register unchanged.
REQ-023 Without AXIL_WSTRB_EN, W_STRB SHALL be ignored and every valid write SHALL update all 32 bits.

Verification
REQ-024 The bench SHALL cover these scenarios (stimulus -> required response):
- Reset, then read 0x00..0x0C -> R_DATA=0, R_RESP=00 for each.
- AW=0x04 and W=0xDEADBEEF (STRB=F) in the same cycle, then read 0x04 -> B_RESP=00 one cycle after the handshakes; R_DATA=0xDEADBEEF.
- W first, then AW=0x08 three cycles later with data 0x12345678 -> accepted in either order; B_VALID one cycle after the AW handshake; REG2=0x12345678.
- Write 0x10 and 0x06, and read 0x20 -> B_RESP=10 and R_RESP=10 with R_DATA=0; registers unchanged.
- B_READY held low for 4 cycles after B_VALID -> B_VALID and B_RESP stable; AW_READY stays low while a new AW_VALID is pending.
- With AXIL_WSTRB_EN: REG1=0xFFFFFFFF, then write 0x00000000 with STRB=4'b0101 -> REG1=0xFF00FF00.
